bcd_sseg_writer: RTL

//  Drives the sseg_array write port from a bin2bcd result, replacing per-digit MCU writes.
//  It takes a sign and a BCD_N-digit BCD word and places them in a field of the

---
 rtl/bcd_sseg_writer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bcd_sseg_writer.sv
// Writes a signed BCD field into the seven-segment array, one digit per cycle:
// the sign position first, then the digits from most to least significant.
//
// state | meaning
// IDLE  | ready; latches request on start
// LOAD  | range check and keep-mask build; first (sign) write is issued on exit
// WRITE | one digit write per cycle, most-significant first
// DONE  | one-cycle tick slot (done or err), then back to IDLE
module bcd_sseg_writer #(
  parameter int BCD_N     = 4,
  parameter int SSEG_BITS = 5,
  parameter int SSEG_N    = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [SSEG_BITS-1:0] base,
  input  logic                 sign,
  input  logic [4*BCD_N-1:0]   bcd,
  input  logic [BCD_N-1:0]     dp_mask,
  input  logic                 blank_lz,
  output logic                 ready,
  output logic                 done_tick,
  output logic                 err_tick,
  output logic                 wr,
  output logic [SSEG_BITS-1:0] sel,
  output logic                 en,
  output logic                 o_sign,
  output logic                 dp,
  output logic [3:0]           val
);

  localparam int CW = (BCD_N > 1) ? $clog2(BCD_N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t               state;
  logic [SSEG_BITS-1:0] base_q;
  logic                 sign_q;
  logic [4*BCD_N-1:0]   bcd_q;
  logic [BCD_N-1:0]     dp_q;
  logic                 blank_q;
  logic [BCD_N-1:0]     keep_q;
  logic [CW-1:0]        cnt;
  logic                 last_q;

  logic [SSEG_BITS:0]   field_top;
  logic                 out_of_range;
  logic [BCD_N-1:0]     keep_c;
  logic                 seen;
  logic [3:0]           cur_val;
  logic                 cur_dp;
  logic                 cur_keep;

  always_comb begin
    field_top    = {1'b0, base_q} + (SSEG_BITS+1)'(BCD_N);
    out_of_range = field_top > (SSEG_BITS+1)'(SSEG_N-1);
  end

  // A digit stays lit once anything at or above it is significant.
  always_comb begin
    seen   = ~blank_q;
    keep_c = '0;
    for (int k = BCD_N-1; k >= 0; k--) begin
      seen      = seen | (bcd_q[4*k +: 4] != 4'd0) | dp_q[k];
      keep_c[k] = seen | (k == 0);
    end
  end

  always_comb begin
    cur_val  = 4'd0;
    cur_dp   = 1'b0;
    cur_keep = 1'b0;
    for (int k = 0; k < BCD_N; k++) begin
      if (cnt == CW'(k)) begin
        cur_val  = bcd_q[4*k +: 4];
        cur_dp   = dp_q[k];
        cur_keep = keep_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      err_tick  <= 1'b0;
      wr        <= 1'b0;
      sel       <= '0;
      en        <= 1'b0;
      o_sign    <= 1'b0;
      dp        <= 1'b0;
      val       <= 4'd0;
      base_q    <= '0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
      dp_q      <= '0;
      blank_q   <= 1'b0;
      keep_q    <= '0;
      cnt       <= '0;
      last_q    <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      err_tick  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q  <= base;
            sign_q  <= sign;
            bcd_q   <= bcd;
            dp_q    <= dp_mask;
            blank_q <= blank_lz;
            ready   <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (out_of_range) begin
            err_tick <= 1'b1;
            state    <= DONE;
          end else begin
            // Sign slot; a zero magnitude never shows a minus.
            keep_q <= keep_c;
            wr     <= 1'b1;
            sel    <= base_q + SSEG_BITS'(BCD_N);
            en     <= sign_q & (|bcd_q);
            o_sign <= 1'b1;
            dp     <= 1'b0;
            val    <= 4'd0;
            cnt    <= CW'(BCD_N-1);
            last_q <= 1'b0;
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (last_q) begin
            wr        <= 1'b0;
            en        <= 1'b0;
            o_sign    <= 1'b0;
            dp        <= 1'b0;
            val       <= 4'd0;
            done_tick <= 1'b1;
            state     <= DONE;
          end else begin
            wr     <= 1'b1;
            sel    <= base_q + SSEG_BITS'(cnt);
            en     <= cur_keep;
            o_sign <= 1'b0;
            dp     <= cur_dp;
            val    <= cur_val;
            if (cnt == '0) last_q <= 1'b1;
            else           cnt    <= cnt - 1'b1;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
